regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have no parameters; data width fixed at 32, register index width fixed at 5.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port a_valid, input, 1, execute-unit writeback request.
REQ-005 SHALL have port a_rd, input, 5, execute-unit destination register.
REQ-006 SHALL have port a_data, input, 32, execute-unit write data.
REQ-007 SHALL have port a_ready, output, 1, execute-unit request accepted this cycle.
REQ-008 SHALL have ports b_valid, b_rd and b_data, inputs, 1/5/32, load-unit writeback request.
REQ-009 SHALL have port b_ready, output, 1, load-unit request accepted this cycle.
REQ-010 SHALL have ports issue_valid and issue_rd, inputs, 1/5, instruction issued that will write issue_rd.
REQ-011 SHALL have port flush, input, 1, clears all pending marks.
REQ-012 SHALL have ports rs1_address and rs2_address, inputs, 5, hazard query addresses.
REQ-013 SHALL have ports rs1_busy and rs2_busy, outputs, 1, the queried register has a write outstanding.
REQ-014 SHALL have ports wr_enable, wr_address and wr_data, outputs, 1/5/32, registered drive of the register-file write port.
REQ-015 SHALL have port pending_count, output, 6, number of registers currently marked pending.

Function
REQ-016 SHALL accept at most one request per cycle; a_ready and b_ready are combinational from the valids and the round-robin pointer, and are never both 1.
REQ-017 SHALL make a request accepted only when its valid and ready are both 1 in the same cycle; ready SHALL NOT depend on rd or data.
REQ-018 SHALL grant the sole valid requester when only one is valid.
REQ-019 SHALL grant the requester not granted most recently when both are valid; the pointer updates only on a conflict grant.
REQ-020 SHALL, on the edge following acceptance, register wr_address and wr_data from the winner, with wr_enable=1 if its rd is non-zero; latency is one cycle.
REQ-021 SHALL drive wr_enable=0 the cycle after no acceptance, and after acceptance of rd=0; wr_address and wr_data then hold their previous values.
REQ-022 SHALL keep a 31-entry pending vector for x1..x31; x0 is never pending.
REQ-023 SHALL set pending[issue_rd] at the edge where issue_valid=1 and issue_rd is non-zero.
REQ-024 SHALL clear pending[wr_address] at the edge where wr_enable=1, which is the commit edge, so busy holds until the register file holds the data.
REQ-025 SHALL let set win over clear when both target the same register at the same edge.
REQ-026 SHALL, when flush=1, clear every pending bit at that edge except a simultaneous issue set; flush SHALL NOT cancel a registered wr_enable or a request accepted that cycle.
REQ-027 SHALL produce rs1_busy and rs2_busy combinationally as pending[address], and 0 for address 0.
REQ-028 SHALL register pending_count equal to the popcount of the next pending vector.
REQ-029 SHALL NOT increment the count when a set targets an already-pending bit, and SHALL NOT decrement it when a commit targets a non-pending bit.
REQ-030 SHALL produce a net count change of 0 when a set and a clear on different registers occur at the same edge.

Reset
REQ-031 SHALL, while reset_n=0, force asynchronously: wr_enable=0, wr_address=0, wr_data=0, pending vector all 0, pending_count=0, round-robin pointer set so A wins the first conflict.
REQ-032 SHALL drop any request presented while reset_n=0, leaving no write and no pending change afterward.
REQ-033 SHALL resume normal operation from the first rising clk edge after reset_n deasserts.

Verification
REQ-034 SHALL cover: issue_rd=5, then a_valid with a_rd=5 and a_data=0xDEADBEEF -> a_ready=1; the next cycle wr_enable=1, wr_address=5, wr_data=0xDEADBEEF and rs1_busy(5)=1; after that edge rs1_busy=0 and pending_count returns 1->0.
REQ-035 SHALL cover: a_valid and b_valid both high for 4 cycles -> grants A,B,A,B, each grant followed by one write.
REQ-036 SHALL cover: b_valid with b_rd=0 -> b_ready=1, wr_enable stays 0, pending_count unchanged.
REQ-037 SHALL cover: issue of x7 on the same edge as a commit of x7 -> pending[7] stays 1 and pending_count unchanged.
REQ-038 SHALL cover: x3, x4 and x9 pending, then flush on the same edge as issue of x12 -> only x12 pending, pending_count=1.
REQ-039 SHALL cover: reset_n pulsed low mid-write -> wr_enable=0 immediately without waiting for clk, and all busy outputs read 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin merge of execute and load writebacks onto one
// register-file write port, with a pending scoreboard for hazard queries.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  input  logic [4:0]  rs1_address,
  input  logic [4:0]  rs2_address,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        wr_enable,
  output logic [4:0]  wr_address,
  output logic [31:0] wr_data,
  output logic [5:0]  pending_count
);

  logic        b_pri;
  logic        vld_p0;
  logic [4:0]  rd_p0;
  logic [31:0] data_p0;
  logic [31:0] pending;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_nxt;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

  // b_pri=1 means B wins the next conflict; only a conflict grant moves it.
  always_comb begin
    a_ready = a_valid && (!b_valid || !b_pri);
    b_ready = b_valid && (!a_valid || b_pri);
  end

  // Stage p0: select the winning request
  always_comb begin
    vld_p0  = a_ready || b_ready;
    rd_p0   = a_ready ? a_rd   : b_rd;
    data_p0 = a_ready ? a_data : b_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_pri <= 1'b0;
    end else if (a_valid && b_valid) begin
      b_pri <= a_ready;
    end
  end

  // Stage p1: registered write port; rd=0 acceptances leave address/data untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_enable  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      wr_enable <= vld_p0 && (rd_p0 != 5'd0);
      if (vld_p0 && (rd_p0 != 5'd0)) begin
        wr_address <= rd_p0;
        wr_data    <= data_p0;
      end
    end
  end

  // Clear on the commit edge so busy covers the write still in flight; set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_rd != 5'd0)) set_mask[issue_rd] = 1'b1;
    if (wr_enable) clr_mask[wr_address] = 1'b1;
    pending_nxt = flush ? 32'd0 : (pending & ~clr_mask);
    pending_nxt = (pending_nxt | set_mask) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pending_nxt;
      pending_count <= popcount(pending_nxt);
    end
  end

  always_comb begin
    rs1_busy = (rs1_address != 5'd0) && pending[rs1_address];
    rs2_busy = (rs2_address != 5'd0) && pending[rs2_address];
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table with write-port scoreboard, then
// hand-written reset and post-reset arbitration sequences.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wr_enable;
  logic [4:0]  wr_address;
  logic [31:0] wr_data;
  logic [5:0]  pending_count;

  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1_address(rs1_address), .rs2_address(rs2_address),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data),
    .pending_count(pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ear;
    logic        ebr;
    logic        eb1;
    logic        eb2;
    logic [5:0]  ecnt;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic bv, input logic [4:0] brd, input logic [31:0] bd,
    input logic iv, input logic [4:0] ird, input logic fl,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic ear, input logic ebr, input logic eb1, input logic eb2,
    input logic [5:0] ecnt);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
    v.iv = iv; v.ird = ird; v.fl = fl; v.r1 = r1; v.r2 = r2;
    v.ear = ear; v.ebr = ebr; v.eb1 = eb1; v.eb2 = eb2; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    issue_valid = 0; issue_rd = 0; flush = 0;
  endtask

  initial begin
    wr_t exp_w;
    wr_t got_w;
    idle();
    rs1_address = 0; rs2_address = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_enable", 32'(wr_enable), 32'd0);
    chk("reset_wr_address", 32'(wr_address), 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_count", 32'(pending_count), 32'd0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    //           av ard  ad            bv brd bd           iv ird fl r1  r2  ear ebr eb1 eb2 cnt
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 5,  0, 5,  0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0,            0, 0,  0, 5,  0,  1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 5,  0,  0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 5,  0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  32'hA1,       1, 2,  32'hB1,       0, 0,  0, 0,  0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  32'hA2,       1, 2,  32'hB2,       0, 0,  0, 0,  0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1,  32'hA3,       1, 2,  32'hB3,       0, 0,  0, 0,  0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  32'hA4,       1, 2,  32'hB4,       0, 0,  0, 0,  0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            1, 0,  32'h55,       0, 0,  0, 0,  0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 10, 32'h1010,     0, 0,  0,            0, 0,  0, 0,  0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            1, 11, 32'h1111,     0, 0,  0, 0,  0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 16, 32'hC0,       1, 17, 32'hC1,       0, 0,  0, 0,  0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 0,  0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 7,  0, 7,  0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 7,  32'h77,       0, 0,  0,            0, 0,  0, 7,  0,  1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 7,  0, 7,  0,  0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 7,  0,  0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 7,  32'h78,       0, 0,  0,            0, 0,  0, 7,  0,  1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 3,  0, 7,  3,  0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 4,  0, 7,  3,  0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 9,  0, 4,  9,  0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 9,  0, 4,  9,  0, 0, 1, 1, 3));
    vecs.push_back(mk(1, 20, 32'h2020,     0, 0,  0,            0, 0,  0, 20, 3,  1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 20, 9,  0, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 12, 1, 3,  12, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 12, 3,  0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 0,  0, 0,  9,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 12, 32'h1212,     0, 0,  0,            0, 0,  0, 12, 0,  1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  1, 12, 0,  0, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_data = vecs[i].bd;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird; flush = vecs[i].fl;
      rs1_address = vecs[i].r1; rs2_address = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
      chk($sformatf("v%0d_rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].eb1));
      chk($sformatf("v%0d_rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].eb2));
      if (vecs[i].ear && vecs[i].ard != 0) begin
        exp_w.we = 1; exp_w.wa = vecs[i].ard; exp_w.wd = vecs[i].ad;
      end else if (vecs[i].ebr && vecs[i].brd != 0) begin
        exp_w.we = 1; exp_w.wa = vecs[i].brd; exp_w.wd = vecs[i].bd;
      end else begin
        exp_w.we = 0; exp_w.wa = last_wa; exp_w.wd = last_wd;
      end
      last_wa = exp_w.wa; last_wd = exp_w.wd;
      sb.push_back(exp_w);
      @(posedge clk);
      #1;
      got_w = sb.pop_front();
      chk($sformatf("v%0d_wr_enable", i), 32'(wr_enable), 32'(got_w.we));
      chk($sformatf("v%0d_wr_address", i), 32'(wr_address), 32'(got_w.wa));
      chk($sformatf("v%0d_wr_data", i), wr_data, got_w.wd);
      chk($sformatf("v%0d_pending_count", i), 32'(pending_count), 32'(vecs[i].ecnt));
    end

    // Asynchronous reset landing while a write is on the port
    idle();
    a_valid = 1; a_rd = 6; a_data = 32'h66; issue_valid = 1; issue_rd = 6;
    rs1_address = 6; rs2_address = 12;
    @(posedge clk);
    #1;
    idle();
    chk("pre_rst_wr_enable", 32'(wr_enable), 32'd1);
    chk("pre_rst_count", 32'(pending_count), 32'd1);
    chk("pre_rst_rs1_busy", 32'(rs1_busy), 32'd1);
    #2;
    reset_n = 0;
    #1;
    chk("rst_wr_enable", 32'(wr_enable), 32'd0);
    chk("rst_wr_address", 32'(wr_address), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_count", 32'(pending_count), 32'd0);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("rst_rs2_busy", 32'(rs2_busy), 32'd0);

    // Requests presented during reset leave nothing behind
    a_valid = 1; a_rd = 8; a_data = 32'h88; b_valid = 1; b_rd = 9; b_data = 32'h99;
    issue_valid = 1; issue_rd = 8; rs1_address = 8; rs2_address = 9;
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_wr_enable", 32'(wr_enable), 32'd0);
    chk("post_rst_count", 32'(pending_count), 32'd0);
    chk("post_rst_rs1_busy", 32'(rs1_busy), 32'd0);

    // Pointer was left favouring B; reset must hand the first conflict to A
    a_valid = 1; a_rd = 13; a_data = 32'hA; b_valid = 1; b_rd = 14; b_data = 32'hB;
    #1;
    chk("post_rst_a_ready", 32'(a_ready), 32'd1);
    chk("post_rst_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_conflict_b_ready", 32'(b_ready), 32'd1);
    idle();
    chk("post_rst_wr_enable2", 32'(wr_enable), 32'd1);
    chk("post_rst_wr_address", 32'(wr_address), 32'd13);
    chk("post_rst_wr_data", wr_data, 32'hA);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
